// File: rtl/impl_mon_pkg.sv
// impl_mon_pkg: shared limits and parameter-legality check for the implication monitor
package impl_mon_pkg;
    localparam int IMPL_MON_DELAY_MAX     = 8;
    localparam int IMPL_MON_CNT_W_DEFAULT = 8;
    localparam int IMPL_MON_CNT_W_MIN     = 2;
    localparam int IMPL_MON_CNT_W_MAX     = 16;

    function automatic bit impl_mon_params_ok(input int delay, input int cnt_w);
        return delay >= 1 && delay <= IMPL_MON_DELAY_MAX &&
               cnt_w >= IMPL_MON_CNT_W_MIN && cnt_w <= IMPL_MON_CNT_W_MAX;
    endfunction
endpackage

// File: rtl/impl_mon_sat_counter.sv
// impl_mon_sat_counter: saturating up-counter with synchronous clear
module impl_mon_sat_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         ASYNCRESETN,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    // count up on inc, stick at all-ones, clear has priority
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN)
            count <= '0;
        else
            count <= clr ? '0 : (inc && count != '1) ? count + 1'b1 : count;
    end
endmodule

// File: rtl/implication_monitor.sv
// implication_monitor: hardware check of "antecedent |-> ##DELAY consequent"; IMPL_MON_PASS_COUNT_EN adds pass_count
module implication_monitor
    import impl_mon_pkg::*;
#(
    parameter int DELAY = 1,
    parameter int CNT_W = IMPL_MON_CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             en,
    input  logic             antecedent,
    input  logic             consequent,
    input  logic             clear,
    output logic             violation,
    output logic             fail_sticky,
    output logic [CNT_W-1:0] fail_count,
`ifdef IMPL_MON_PASS_COUNT_EN
    output logic [CNT_W-1:0] pass_count,
`endif
    output logic             pending
);
    if (!impl_mon_params_ok(DELAY, CNT_W)) begin : g_bad_params
        $error("implication_monitor: illegal DELAY=%0d or CNT_W=%0d", DELAY, CNT_W);
    end

    logic [DELAY-1:0] obl;
    logic             mature;
    logic             fail_hit;

    assign mature   = obl[DELAY-1];
    assign fail_hit = mature & ~consequent;
    assign pending  = |obl;

    // obligation pipeline plus registered violation pulse and sticky flag; clear flushes everything
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            obl         <= '0;
            violation   <= 1'b0;
            fail_sticky <= 1'b0;
        end else begin
            obl         <= clear ? '0 : (obl << 1) | DELAY'(en & antecedent);
            violation   <= ~clear & fail_hit;
            fail_sticky <= ~clear & (fail_sticky | fail_hit);
        end
    end

    impl_mon_sat_counter #(.W(CNT_W)) u_fail_cnt (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .inc         (fail_hit),
        .clr         (clear),
        .count       (fail_count)
    );

`ifdef IMPL_MON_PASS_COUNT_EN
    impl_mon_sat_counter #(.W(CNT_W)) u_pass_cnt (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .inc         (mature & consequent),
        .clr         (clear),
        .count       (pass_count)
    );
`endif
endmodule

// File: tb/tb_implication_monitor.sv
// tb_implication_monitor: directed checks of implication_monitor at DELAY=3, CNT_W=2
module tb_implication_monitor;
    localparam int DELAY = 3;
    localparam int CNT_W = 2;

    logic             CLK = 1'b0;
    logic             ASYNCRESETN = 1'b0;
    logic             en = 1'b1;
    logic             antecedent = 1'b0;
    logic             consequent = 1'b0;
    logic             clear = 1'b0;
    logic             violation;
    logic             fail_sticky;
    logic [CNT_W-1:0] fail_count;
`ifdef IMPL_MON_PASS_COUNT_EN
    logic [CNT_W-1:0] pass_count;
`endif
    logic             pending;

    int n_checks = 0;
    int n_fail   = 0;

    implication_monitor #(.DELAY(DELAY), .CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .en          (en),
        .antecedent  (antecedent),
        .consequent  (consequent),
        .clear       (clear),
        .violation   (violation),
        .fail_sticky (fail_sticky),
        .fail_count  (fail_count),
`ifdef IMPL_MON_PASS_COUNT_EN
        .pass_count  (pass_count),
`endif
        .pending     (pending)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // reset state
        #2;
        check("rst_violation", violation, 0);
        check("rst_sticky", fail_sticky, 0);
        check("rst_count", fail_count, 0);
        check("rst_pending", pending, 0);
        #10 ASYNCRESETN = 1'b1;

        // single obligation answered by consequent
        tick();
        antecedent = 1'b1;
        tick();
        antecedent = 1'b0;
        check("pass_pending", pending, 1);
        tick();
        tick();
        check("pass_no_early_viol", violation, 0);
        consequent = 1'b1;
        tick();
        consequent = 1'b0;
        check("pass_violation", violation, 0);
        check("pass_pending_done", pending, 0);
        tick();
        check("pass_count_zero", fail_count, 0);
        check("pass_sticky_zero", fail_sticky, 0);

        // three back-to-back failures
        antecedent = 1'b1;
        tick(); tick(); tick();
        antecedent = 1'b0;
        check("b2b_pre_viol", violation, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("b2b_viol_%0d", i), violation, 1);
            check($sformatf("b2b_count_%0d", i), fail_count, i);
        end
        check("b2b_sticky", fail_sticky, 1);
        check("b2b_pending", pending, 0);
        tick();
        check("b2b_viol_end", violation, 0);

        // clear then five failures to saturate
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_count", fail_count, 0);
        check("clr_sticky", fail_sticky, 0);
        antecedent = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        antecedent = 1'b0;
        for (int i = 6; i <= 8; i++) tick();
        check("sat_count", fail_count, 3);
        check("sat_viol_5th", violation, 1);
        check("sat_sticky", fail_sticky, 1);
        tick();
        check("sat_viol_end", violation, 0);
        check("sat_count_hold", fail_count, 3);

        // clear on the maturity edge wins over violation and new antecedent
        antecedent = 1'b1;
        tick();
        antecedent = 1'b0;
        tick(); tick();
        clear = 1'b1;
        antecedent = 1'b1;
        tick();
        clear = 1'b0;
        antecedent = 1'b0;
        check("flush_viol", violation, 0);
        check("flush_pending", pending, 0);
        check("flush_count", fail_count, 0);
        check("flush_sticky", fail_sticky, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("flush_quiet_%0d", i), violation, 0);
        end

        // en low blocks new obligations but not those in flight
        en = 1'b0;
        antecedent = 1'b1;
        tick();
        check("en_block_pending", pending, 0);
        en = 1'b1;
        tick();
        en = 1'b0;
        tick(); tick();
        check("en_inflight_pre", violation, 0);
        tick();
        antecedent = 1'b0;
        en = 1'b1;
        check("en_inflight_viol", violation, 1);
        check("en_inflight_count", fail_count, 1);
        check("en_inflight_pending", pending, 0);
        tick();
        check("en_blocked_viol", violation, 0);

        // asynchronous reset mid-obligation
        antecedent = 1'b1;
        tick();
        antecedent = 1'b0;
        tick();
        #2 ASYNCRESETN = 1'b0;
        #1;
        check("arst_pending", pending, 0);
        check("arst_sticky", fail_sticky, 0);
        check("arst_count", fail_count, 0);
        check("arst_viol", violation, 0);
        #1 ASYNCRESETN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("arst_quiet_%0d", i), violation, 0);
        end

        // mixed pass/fail with a blocked fourth antecedent
        begin
            logic [6:0] ant_v, en_v, cons_v, viol_v;
            ant_v  = 7'b0001111;
            en_v   = 7'b1110111;
            cons_v = 7'b0101000;
            viol_v = 7'b0010000;
            for (int i = 0; i < 7; i++) begin
                antecedent = ant_v[i];
                en         = en_v[i];
                consequent = cons_v[i];
                tick();
                check($sformatf("mix_viol_%0d", i + 1), violation, int'(viol_v[i]));
            end
            antecedent = 1'b0;
            consequent = 1'b0;
            en = 1'b1;
            check("mix_fail_count", fail_count, 1);
`ifdef IMPL_MON_PASS_COUNT_EN
            check("mix_pass_count", pass_count, 2);
`endif
            check("mix_pending", pending, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/implication_monitor.md
IMPLICATION_MONITOR -- requirements
Module: implication_monitor

Interface
REQ-001 Parameter DELAY, default 1: antecedent-to-consequent distance in cycles, legal 1..8.
REQ-002 Parameter CNT_W, default 8: width of the failure (and pass) counters, legal 2..16.
REQ-003 CLK  input  1  sole clock, rising-edge active.
REQ-004 ASYNCRESETN  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  when high, antecedent may open new obligations.
REQ-006 antecedent  input  1  property trigger, sampled each rising edge.
REQ-007 consequent  input  1  required response, sampled DELAY edges after the trigger.
REQ-008 clear  input  1  synchronous clear of the obligations, the sticky flag and the counters.
REQ-009 violation  output  1  registered one-cycle pulse per failed obligation.
REQ-010 fail_sticky  output  1  set on the first violation; held until clear or reset.
REQ-011 fail_count  output  CNT_W  saturating count of violations.
REQ-012 pending  output  1  high while any obligation is outstanding.

Function
REQ-013 Shall check "antecedent |-> ##DELAY consequent" in hardware, with no overlapping-obligation limit.
REQ-014 Shall keep obligations in a DELAY-bit shift register; at each edge, the entry bit loads en & antecedent and all entries shift one stage.
REQ-015 An obligation opened at edge k shall mature at edge k+DELAY and be checked against consequent sampled at that edge.
REQ-016 At maturity with consequent low: violation shall be high for the cycle following edge k+DELAY, fail_sticky shall set, and fail_count shall increment.
REQ-017 At maturity with consequent high: no violation.
REQ-018 Back-to-back antecedents shall each be checked independently; N failures shall produce N violation pulses on consecutive cycles.
REQ-019 fail_count shall saturate at 2^CNT_W-1 and never wrap; fail_sticky and violation remain functional at saturation.
REQ-020 en low shall block new obligations only; obligations already in flight still mature and are checked.
REQ-021 consequent shall be ignored on any edge where no obligation matures.
REQ-022 clear at edge j shall flush all obligations, including any maturing at j, and zero fail_sticky, fail_count and violation; clear wins over a simultaneous violation or antecedent.
REQ-023 pending shall be the combinational OR of the shift-register bits.

Reset
REQ-024 While ASYNCRESETN is low, shall immediately force obligations=0, violation=0, fail_sticky=0, fail_count=0, pending=0 (and pass_count=0 when present).
REQ-025 Reset asserted mid-obligation shall discard that obligation with no violation reported.
REQ-026 The first trigger shall be the first edge sampled with ASYNCRESETN high.

Configuration
REQ-027 With macro IMPL_MON_PASS_COUNT_EN defined: add output pass_count (CNT_W), a saturating count of matured obligations whose consequent was high, cleared by clear and by reset.
REQ-028 With IMPL_MON_PASS_COUNT_EN undefined: no pass_count port and no pass-counter logic; all other behaviour is identical.

Structure
REQ-029 Package impl_mon_pkg shall hold IMPL_MON_DELAY_MAX=8, IMPL_MON_CNT_W_DEFAULT=8, and the parameter-legality checking function.
REQ-030 Sub-module impl_mon_sat_counter (parameter W; inputs inc and clr; output count, saturating) shall be instantiated for fail_count and, when enabled, for pass_count.
REQ-031 Illegal DELAY or CNT_W values shall cause an elaboration-time error.

Verification
REQ-032 DELAY=1; antecedent=1 at edge 1, consequent=1 at edge 2 -> violation stays 0; fail_count=0.
REQ-033 DELAY=3; antecedent pulsed at edges 1,2,3, consequent low at edges 4,5,6 -> violation high for 3 consecutive cycles after edge 4; fail_count=3; fail_sticky=1.
REQ-034 CNT_W=2; 5 failures -> fail_count saturates at 3; a 5th violation pulse is still produced.
REQ-035 DELAY=2; antecedent at edge 1, clear at edge 3 with consequent low -> no violation; all counters 0; pending=0 after edge 3.
REQ-036 DELAY=4; antecedent at edge 1, ASYNCRESETN pulsed low between edges 2 and 3 -> all outputs 0 immediately; no violation at edge 5.
REQ-037 IMPL_MON_PASS_COUNT_EN defined; 2 passes and 1 fail with en low for a 4th antecedent -> pass_count=2, fail_count=1.
